// File: rtl/pow_defs.sv
// Shared FSM encodings and default widths for the pow_ctrl exponentiation block.
package pow_defs;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned EXP_W_DEF  = 4;
  localparam int unsigned OUT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SQR  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pow_mul.sv
// Combinational W x W multiplier returning the low half and a flag for a nonzero high half.
module pow_mul #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] prod_lo,
  output logic         hi_nz
);

  logic [2*W-1:0] full;

  always_comb begin
    full    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    prod_lo = full[W-1:0];
    hi_nz   = |full[2*W-1:W];
  end

endmodule

// File: rtl/pow_ctrl.sv
// Square-and-multiply p**q engine with valid/ready handshakes and a sticky overflow flag.
module pow_ctrl
  import pow_defs::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              overflow
);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   base_q, base_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic               ovf_q, ovf_d;

  logic [OUT_W-1:0]   mul_a;
  logic [OUT_W-1:0]   prod_lo;
  logic               prod_hi_nz;
  logic [EXP_W-1:0]   e_shr;

  // Single shared multiplier: SQR squares the base, every other state feeds acc*base.
  assign mul_a = (state_q == SQR) ? base_q : acc_q;
  assign e_shr = e_q >> 1;

  pow_mul #(.W(OUT_W)) u_mul (
    .a       (mul_a),
    .b       (base_q),
    .prod_lo (prod_lo),
    .hi_nz   (prod_hi_nz)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    e_d     = e_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          acc_d   = OUT_W'(1);
          base_d  = OUT_W'(data_in);
          e_d     = exp_in;
          ovf_d   = 1'b0;
          state_d = (exp_in == '0) ? DONE : MUL;
        end
      end
      MUL: begin
        // Only products actually kept count toward overflow.
        if (e_q[0]) begin
          acc_d = prod_lo;
          if (prod_hi_nz) ovf_d = 1'b1;
        end
        state_d = SQR;
      end
      SQR: begin
        if (e_shr == '0) begin
          state_d = DONE;
        end else begin
          base_d  = prod_lo;
          e_d     = e_shr;
          if (prod_hi_nz) ovf_d = 1'b1;
          state_d = MUL;
        end
      end
      DONE: begin
        if (data_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      e_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      e_q     <= e_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_in_ready  = (state_q == IDLE);
  assign data_out_valid = (state_q == DONE);
  assign data_out       = acc_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_pow_ctrl.sv
// Randomized and directed bench for pow_ctrl against a repeated-multiplication reference model.
module tb_pow_ctrl;
  import pow_defs::*;

  localparam int unsigned DATA_W = DATA_W_DEF;
  localparam int unsigned EXP_W  = EXP_W_DEF;
  localparam int unsigned OUT_W  = OUT_W_DEF;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic [EXP_W-1:0]  exp_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [OUT_W-1:0]  data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic              overflow;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pow_ctrl #(.DATA_W(DATA_W), .EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .exp_in         (exp_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: p multiplied by itself q times, keeping the low OUT_W bits;
  // the running true value only grows (p >= 1), so any wrap means true overflow.
  task automatic model(input int unsigned p, input int unsigned q,
                       output longint unsigned res, output bit ovf, output int unsigned lat);
    longint unsigned r;
    int m;
    r   = 1;
    ovf = 0;
    for (int unsigned i = 0; i < q; i++) begin
      r = r * longint'(p);
      if (r >= (64'd1 << OUT_W)) begin
        ovf = 1;
        r   = r & ((64'd1 << OUT_W) - 1);
      end
    end
    res = r;
    m = -1;
    for (int i = 0; i < EXP_W; i++) if (((q >> i) & 1) != 0) m = i;
    lat = (q == 0) ? 1 : 2 * (m + 1) + 1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the block back in IDLE.
  task automatic run_op(input int unsigned p, input int unsigned q, input int unsigned stall);
    longint unsigned exp_res;
    bit              exp_ovf;
    int unsigned     exp_lat;
    int unsigned     cyc;
    logic [OUT_W-1:0] held;
    bit              stable;
    model(p, q, exp_res, exp_ovf, exp_lat);
    chk("ready_before_accept", data_in_ready, 1);
    data_in        = DATA_W'(p);
    exp_in         = EXP_W'(q);
    data_in_valid  = 1'b1;
    data_out_ready = (stall == 0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in       = '0;
    exp_in        = '0;
    cyc = 1;
    while (!data_out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("latency p=%0d q=%0d", p, q), cyc, exp_lat);
    chk($sformatf("data_out p=%0d q=%0d", p, q), data_out, exp_res);
    chk($sformatf("overflow p=%0d q=%0d", p, q), overflow, exp_ovf);
    held   = data_out;
    stable = 1;
    for (int unsigned s = 0; s < stall; s++) begin
      data_in_valid = 1'($urandom);
      data_in       = DATA_W'($urandom);
      exp_in        = EXP_W'($urandom);
      @(posedge clk); #1;
      if (!data_out_valid || data_out !== held || overflow !== exp_ovf || data_in_ready)
        stable = 0;
    end
    if (stall != 0) chk($sformatf("stall_stable p=%0d q=%0d", p, q), stable, 1);
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("released_valid_low", data_out_valid, 0);
    chk("released_ready_high", data_in_ready, 1);
  endtask

  initial begin
    bit saw_valid;
    rst            = 1'b1;
    data_in        = '0;
    exp_in         = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_ready", data_in_ready, 1);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3, 4, 0);
    run_op(0, 0, 0);
    run_op(200, 0, 0);
    run_op(255, 4, 0);
    run_op(2, 15, 0);
    run_op(16, 8, 0);
    run_op(255, 15, 0);
    run_op(5, 3, 10);
    run_op(1, 15, 0);
    run_op(0, 7, 2);

    // Abort mid-computation with an asynchronous reset pulse.
    data_in       = DATA_W'(7);
    exp_in        = EXP_W'(13);
    data_in_valid = 1'b1;
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_data_out", data_out, 0);
    chk("abort_valid", data_out_valid, 0);
    chk("abort_ready", data_in_ready, 1);
    chk("abort_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (data_out_valid) saw_valid = 1;
    end
    chk("abort_no_result", saw_valid, 0);
    run_op(2, 10, 0);

    for (int i = 0; i < 30; i++)
      run_op($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
